// File: rtl/bitstream_loader_if.sv
// Byte stream into the loader and readback bytes out of it.
// The host side is the master; the loader is the slave.
interface bitstream_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] rb_data;
  logic       rb_valid;

  modport master (output in_data, in_valid, input in_ready, rb_data, rb_valid);
  modport slave  (input in_data, in_valid, output in_ready, rb_data, rb_valid);
endinterface

// File: rtl/bitstream_loader.sv
// Shifts config bytes LSB-first into the tinyFPGA chain under a divided prog_clk,
// captures the old chain contents as readback bytes, then pulses fpga_rst.
module bitstream_loader #(
  parameter int CHAIN_LEN  = 102,
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  bitstream_loader_if.slave   bus,
  output logic                prog_en,
  output logic                prog_clk,
  output logic                prog_data,
  input  logic                prog_out,
  output logic                fpga_rst
);
  localparam int MX = (CLK_DIV > RST_CYCLES) ? CLK_DIV : RST_CYCLES;
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, RELEASE, FIN} state_t;

  state_t        state, state_n;
  logic          busy_n, done_n, ready, ready_n, rb_pulse, rb_pulse_n;
  logic [7:0]    rb_byte, rb_byte_n;
  logic          prog_en_n, prog_clk_n, prog_data_n, fpga_rst_n;
  logic [BW-1:0] bits_sent, bits_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    tx_sr, tx_n, rx_sr, rx_n, rx_bit;

  assign bus.in_ready = ready;
  assign bus.rb_data  = rb_byte;
  assign bus.rb_valid = rb_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b0;
      rb_pulse  <= 1'b0;
      rb_byte   <= '0;
      prog_en   <= 1'b0;
      prog_clk  <= 1'b0;
      prog_data <= 1'b0;
      fpga_rst  <= 1'b0;
      bits_sent <= '0;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      done      <= done_n;
      ready     <= ready_n;
      rb_pulse  <= rb_pulse_n;
      rb_byte   <= rb_byte_n;
      prog_en   <= prog_en_n;
      prog_clk  <= prog_clk_n;
      prog_data <= prog_data_n;
      fpga_rst  <= fpga_rst_n;
      bits_sent <= bits_n;
      cnt       <= cnt_n;
      tx_sr     <= tx_n;
      rx_sr     <= rx_n;
    end
  end

  always_comb begin
    state_n     = state;
    busy_n      = busy;
    done_n      = 1'b0;
    ready_n     = ready;
    rb_pulse_n  = 1'b0;
    rb_byte_n   = rb_byte;
    prog_en_n   = prog_en;
    prog_clk_n  = prog_clk;
    prog_data_n = prog_data;
    fpga_rst_n  = fpga_rst;
    bits_n      = bits_sent;
    cnt_n       = cnt;
    tx_n        = tx_sr;
    rx_n        = rx_sr;
    rx_bit      = rx_sr;
    rx_bit[bits_sent[2:0]] = prog_out;
    unique case (state)
      IDLE: if (start) begin
        state_n   = FETCH;
        busy_n    = 1'b1;
        prog_en_n = 1'b1;
        ready_n   = 1'b1;
        bits_n    = '0;
      end
      // ready is held high for the whole of FETCH, so in_valid alone is the handshake
      FETCH: if (bus.in_valid) begin
        tx_n        = bus.in_data;
        prog_data_n = bus.in_data[0];
        ready_n     = 1'b0;
        cnt_n       = '0;
        state_n     = SHIFT;
      end
      SHIFT: begin
        if (cnt != CW'(CLK_DIV - 1)) begin
          cnt_n = cnt + CW'(1);
        end else if (!prog_clk) begin
          // last low cycle: capture the chain tail before the fabric shifts
          cnt_n      = '0;
          prog_clk_n = 1'b1;
          rx_n       = rx_bit;
          if (bits_sent[2:0] == 3'd7 || bits_sent == BW'(CHAIN_LEN - 1)) begin
            rb_byte_n  = rx_bit;
            rb_pulse_n = 1'b1;
            rx_n       = '0;
          end
        end else begin
          cnt_n      = '0;
          prog_clk_n = 1'b0;
          bits_n     = bits_sent + BW'(1);
          tx_n       = tx_sr >> 1;
          if (bits_n == BW'(CHAIN_LEN)) begin
            state_n     = RELEASE;
            prog_en_n   = 1'b0;
            prog_data_n = 1'b0;
            fpga_rst_n  = 1'b1;
          end else if (bits_n[2:0] == 3'd0) begin
            state_n = FETCH;
            ready_n = 1'b1;
          end else begin
            prog_data_n = tx_sr[1];
          end
        end
      end
      RELEASE: begin
        if (cnt == CW'(RST_CYCLES - 1)) begin
          fpga_rst_n = 1'b0;
          done_n     = 1'b1;
          state_n    = FIN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FIN: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bitstream_loader.sv
// Random and directed loads against a bit-level model of the configuration chain.
module tb_bitstream_loader;
  localparam int L  = 20;
  localparam int CD = 2;
  localparam int RC = 4;
  localparam int NB = (L + 7) / 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, prog_en, prog_clk, prog_data, prog_out, fpga_rst;

  bitstream_loader_if bus();

  bitstream_loader #(.CHAIN_LEN(L), .CLK_DIV(CD), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus),
    .prog_en(prog_en), .prog_clk(prog_clk), .prog_data(prog_data),
    .prog_out(prog_out), .fpga_rst(fpga_rst)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;

  // Fabric model: the chain shifts prog_data in at the head on each prog_clk rise.
  logic [L-1:0] chain;
  logic         bit_q[$];
  logic [7:0]   rb_q[$];
  int           frst_cnt = 0, done_cnt = 0, overlap = 0, bad_pclk = 0;
  logic         prev_pclk = 1'b0;

  assign prog_out = chain[L-1];

  initial begin
    chain = L'($urandom);
    forever begin
      @(negedge clk);
      if (prog_clk && !prev_pclk) begin
        bit_q.push_back(prog_data);
        chain = {chain[L-2:0], prog_data};
      end
      prev_pclk = prog_clk;
      if (bus.rb_valid) rb_q.push_back(bus.rb_data);
      if (fpga_rst) frst_cnt++;
      if (fpga_rst && prog_en) overlap++;
      if (done) done_cnt++;
      if (prog_clk && !prog_en) bad_pclk++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    repeat (gap) @(posedge clk);
    if (gap >= 40) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 1);
      check("stall_prog_en", prog_en, 1);
      check("stall_prog_clk", prog_clk, 0);
    end
    @(posedge clk); #1 bus.in_valid = 1'b1; bus.in_data = b;
    rdy = 1'b0;
    for (int k = 0; k < 500 && !rdy; k++) begin
      @(negedge clk);
      rdy = bus.in_ready;
    end
    check("accept_ready", rdy, 1);
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
  endtask

  task automatic do_load(input logic [8*NB-1:0] data, input int gap, input bit poke);
    logic [L-1:0]    snap, got, exp_chain;
    logic [8*NB-1:0] exp_rb;
    int b0, r0, f0, d0, o0, p0;
    bit seen;
    snap = chain;
    b0 = bit_q.size(); r0 = rb_q.size();
    f0 = frst_cnt; d0 = done_cnt; o0 = overlap; p0 = bad_pclk;
    pulse_start();
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_prog_en", prog_en, 1);
    check("start_in_ready", bus.in_ready, 1);
    for (int i = 0; i < NB; i++) begin
      send_byte(data[8*i +: 8], (i == 1) ? gap : int'($urandom_range(0, 3)));
      if (poke && i == 1) pulse_start();
    end
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    repeat (8) @(negedge clk);
    check("idle_after_load", busy, 0);

    check("rise_count", bit_q.size() - b0, L);
    for (int i = 0; i < L; i++) got[i] = (b0 + i < bit_q.size()) ? bit_q[b0 + i] : 1'bx;
    check("prog_data_seq", 32'(got), 32'(data[L-1:0]));
    for (int k = 0; k < L; k++) exp_chain[L-1-k] = data[k];
    check("chain_final", 32'(chain), 32'(exp_chain));

    exp_rb = '0;
    for (int k = 0; k < L; k++) exp_rb[k] = snap[L-1-k];
    check("rb_count", rb_q.size() - r0, NB);
    for (int j = 0; j < NB; j++)
      check($sformatf("rb_byte%0d", j), (r0 + j < rb_q.size()) ? rb_q[r0 + j] : 8'hxx,
            exp_rb[8*j +: 8]);

    check("fpga_rst_cycles", frst_cnt - f0, RC);
    check("fpga_rst_with_prog_en", overlap - o0, 0);
    check("done_pulses", done_cnt - d0, 1);
    check("prog_clk_outside_load", bad_pclk - p0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_rb_valid", bus.rb_valid, 0);
    check("rst_rb_data", bus.rb_data, 0);
    check("rst_prog_en", prog_en, 0);
    check("rst_prog_clk", prog_clk, 0);
    check("rst_prog_data", prog_data, 0);
    check("rst_fpga_rst", fpga_rst, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed pattern, repeated so the second pass reads back the first.
    do_load(24'hFF3CA5, 0, 1'b0);
    do_load(24'hFF3CA5, 1, 1'b0);
    // Long in_valid stall between bytes.
    do_load(24'($urandom), 50, 1'b0);

    // Abort a load mid-byte with reset.
    b0 = bit_q.size();
    pulse_start();
    send_byte(8'($urandom), 0);
    for (int k = 0; k < 500 && (bit_q.size() - b0) < 5; k++) @(negedge clk);
    check("abort_reached_bit5", (bit_q.size() - b0) >= 5, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_prog_en", prog_en, 0);
    check("abort_busy", busy, 0);
    check("abort_prog_clk", prog_clk, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_fpga_rst", fpga_rst, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Clean load after abort, with start pulsed while busy.
    do_load(24'($urandom), 2, 1'b1);
    for (int n = 0; n < 3; n++) do_load(24'($urandom), int'($urandom_range(0, 6)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
